// File: rtl/alu_ctrl_seq_if.sv
// Instruction-fetch handshake between instruction memory (master) and the
// control sequencer (slave).
interface alu_ctrl_seq_if;
  logic [15:0] Inst;
  logic        InstValid;
  logic        InstReady;

  modport master (output Inst, output InstValid, input InstReady);
  modport slave  (input Inst, input InstValid, output InstReady);
endinterface

// File: rtl/alu_ctrl_seq.sv
// Instruction sequencer: FETCH -> DECODE -> EXEC, decodes 16-bit words into
// regfile/ALU controls and captures ALU flags into the status register.
module alu_ctrl_seq #(
  parameter logic [3:0]  CMP_CODE  = 4'hB,
  parameter logic [15:0] ZEXT_MASK = 16'h0000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  alu_ctrl_seq_if.slave        inst_bus,
  input  logic [4:0]           Flags_i,
  output logic [3:0]           RdestRegLoc_o,
  output logic [3:0]           RsrcRegLoc_o,
  output logic [15:0]          Imm_o,
  output logic                 Imm_s_o,
  output logic [4:0]           OpCode_o,
  output logic                 En_o,
  output logic [4:0]           Psr_o,
  output logic                 Retire_o
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0]  rdest_q, rsrc_q;
  logic [15:0] imm_q;
  logic        imm_s_q;
  logic [4:0]  opcode_q;
  logic        wb_q, upd_q;
  logic [4:0]  psr_q;

  logic [3:0]  rdest_d, rsrc_d;
  logic [15:0] imm_d;
  logic        imm_s_d;
  logic [4:0]  opcode_d;
  logic        wb_d, upd_d;

  logic        accept;
  logic [3:0]  major;
  logic        is_nop, is_cmp;

  assign accept = (state_q == FETCH) && inst_bus.InstValid;
  assign major  = inst_bus.Inst[15:12];
  assign is_nop = (inst_bus.Inst == 16'h0000);
  assign is_cmp = (major == 4'h0) ? (inst_bus.Inst[7:4] == CMP_CODE)
                                  : (major == CMP_CODE);

  // Combinational decode of the presented word; only latched on accept.
  always_comb begin
    rdest_d  = inst_bus.Inst[11:8];
    rsrc_d   = 4'h0;
    imm_d    = 16'h0000;
    imm_s_d  = 1'b0;
    opcode_d = 5'h00;
    if (major == 4'h0) begin
      rsrc_d   = inst_bus.Inst[3:0];
      opcode_d = {1'b0, inst_bus.Inst[7:4]};
    end else begin
      opcode_d = {1'b1, major};
      imm_s_d  = 1'b1;
      if (ZEXT_MASK[major])
        imm_d = {8'h00, inst_bus.Inst[7:0]};
      else
        imm_d = {{8{inst_bus.Inst[7]}}, inst_bus.Inst[7:0]};
    end
    wb_d  = !is_nop && !is_cmp;
    upd_d = !is_nop;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      state_q <= FETCH;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (inst_bus.InstValid) state_d = DECODE;
      DECODE:  state_d = EXEC;
      EXEC:    state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    inst_bus.InstReady = (state_q == FETCH);
    Retire_o           = (state_q == EXEC);
    En_o               = (state_q == EXEC) && wb_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdest_q  <= 4'h0;
      rsrc_q   <= 4'h0;
      imm_q    <= 16'h0000;
      imm_s_q  <= 1'b0;
      opcode_q <= 5'h00;
      wb_q     <= 1'b0;
      upd_q    <= 1'b0;
    end else if (accept) begin
      rdest_q  <= rdest_d;
      rsrc_q   <= rsrc_d;
      imm_q    <= imm_d;
      imm_s_q  <= imm_s_d;
      opcode_q <= opcode_d;
      wb_q     <= wb_d;
      upd_q    <= upd_d;
    end
  end

  // Flags are sampled at the edge that closes EXEC.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      psr_q <= 5'h00;
    else if ((state_q == EXEC) && upd_q)
      psr_q <= Flags_i;
  end

  assign RdestRegLoc_o = rdest_q;
  assign RsrcRegLoc_o  = rsrc_q;
  assign Imm_o         = imm_q;
  assign Imm_s_o       = imm_s_q;
  assign OpCode_o      = opcode_q;
  assign Psr_o         = psr_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed table, hand-written corner
// sequences and randomized words against a decode model.
module tb_alu_ctrl_seq;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] flags;

  logic [3:0]  rd, rs, rd_z, rs_z;
  logic [15:0] imm, imm_z;
  logic        ims, ims_z, en, en_z, ret, ret_z;
  logic [4:0]  op, op_z, psr, psr_z;

  int checks = 0;
  int failures = 0;
  logic [4:0] psr_m;

  always #5 clk = ~clk;

  alu_ctrl_seq_if bus ();
  alu_ctrl_seq_if bus_z ();
  assign bus_z.Inst      = bus.Inst;
  assign bus_z.InstValid = bus.InstValid;

  alu_ctrl_seq dut (
    .clk_i(clk), .rst_ni(rst_n), .inst_bus(bus.slave), .Flags_i(flags),
    .RdestRegLoc_o(rd), .RsrcRegLoc_o(rs), .Imm_o(imm), .Imm_s_o(ims),
    .OpCode_o(op), .En_o(en), .Psr_o(psr), .Retire_o(ret)
  );

  alu_ctrl_seq #(.ZEXT_MASK(16'h0020)) dut_z (
    .clk_i(clk), .rst_ni(rst_n), .inst_bus(bus_z.slave), .Flags_i(flags),
    .RdestRegLoc_o(rd_z), .RsrcRegLoc_o(rs_z), .Imm_o(imm_z), .Imm_s_o(ims_z),
    .OpCode_o(op_z), .En_o(en_z), .Psr_o(psr_z), .Retire_o(ret_z)
  );

  typedef struct {
    logic [15:0] inst;
    logic [4:0]  flags;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] imm;
    logic [15:0] imm_z;
    logic [4:0]  op;
    logic        ims;
    logic        en;
    logic [4:0]  psr;
  } vec_t;

  typedef struct {
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] imm;
    logic [4:0]  op;
    logic        ims;
    logic        wb;
    logic        upd;
  } dec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decode rules stated arithmetically: immediate is the byte value, or that
  // value minus 256 (mod 2^16) when the top bit is set and not zero-extended.
  function automatic dec_t model(input logic [15:0] w, input logic [15:0] mask);
    dec_t d;
    int   major, b;
    major = int'(w >> 12);
    b     = int'(w & 16'h00FF);
    d.rd  = 4'((w >> 8) & 16'hF);
    if (major == 0) begin
      d.rs  = 4'(w & 16'hF);
      d.op  = 5'((w >> 4) & 16'hF);
      d.imm = 16'h0;
      d.ims = 1'b0;
      d.upd = (w != 16'h0);
      d.wb  = (w != 16'h0) && (((w >> 4) & 16'hF) != 16'hB);
    end else begin
      d.rs  = 4'h0;
      d.op  = 5'(16 + major);
      d.ims = 1'b1;
      if (mask[major] || b < 128) d.imm = 16'(b);
      else d.imm = 16'(b + 65536 - 256);
      d.upd = 1'b1;
      d.wb  = (major != 11);
    end
    return d;
  endfunction

  // Called just after a falling edge with the sequencer in FETCH.
  task automatic do_inst(input logic [15:0] inst, input logic [4:0] f,
                         input logic [3:0] e_rd, input logic [3:0] e_rs,
                         input logic [15:0] e_imm, input logic [15:0] e_imm_z,
                         input logic [4:0] e_op, input logic e_ims,
                         input logic e_en, input logic [4:0] e_psr);
    bus.Inst = inst;
    bus.InstValid = 1'b1;
    chk("fetch_ready", 32'(bus.InstReady), 32'd1);
    @(posedge clk); @(negedge clk);
    bus.InstValid = 1'b0;
    chk("dec_ready", 32'(bus.InstReady), 32'd0);
    chk("dec_en", 32'(en), 32'd0);
    chk("dec_retire", 32'(ret), 32'd0);
    chk("dec_rdest", 32'(rd), 32'(e_rd));
    chk("dec_rsrc", 32'(rs), 32'(e_rs));
    chk("dec_imm", 32'(imm), 32'(e_imm));
    chk("dec_imm_z", 32'(imm_z), 32'(e_imm_z));
    chk("dec_opcode", 32'(op), 32'(e_op));
    chk("dec_imm_s", 32'(ims), 32'(e_ims));
    @(posedge clk); @(negedge clk);
    flags = f;
    chk("exec_en", 32'(en), 32'(e_en));
    chk("exec_retire", 32'(ret), 32'd1);
    chk("exec_ready", 32'(bus.InstReady), 32'd0);
    chk("exec_fields", 32'({rd, rs, imm, op, ims}), 32'({e_rd, e_rs, e_imm, e_op, e_ims}));
    @(posedge clk); @(negedge clk);
    chk("post_psr", 32'(psr), 32'(e_psr));
    chk("post_psr_z", 32'(psr_z), 32'(e_psr));
    chk("post_en", 32'(en), 32'd0);
    chk("post_retire", 32'(ret), 32'd0);
    $display("inst=%h flags=%h rd=%h rs=%h imm=%h imm_z=%h op=%h ims=%b psr=%h",
             inst, f, rd, rs, imm, imm_z, op, ims, psr);
  endtask

  vec_t vecs[7];

  initial begin
    dec_t d;
    logic [15:0] w;
    int acc_n, en_n;
    int acc_at[2];

    vecs[0] = '{16'h0153, 5'h03, 4'h1, 4'h3, 16'h0000, 16'h0000, 5'h05, 1'b0, 1'b1, 5'h03};
    vecs[1] = '{16'h52F0, 5'h0C, 4'h2, 4'h0, 16'hFFF0, 16'h00F0, 5'h15, 1'b1, 1'b1, 5'h0C};
    vecs[2] = '{16'h04B7, 5'h12, 4'h4, 4'h7, 16'h0000, 16'h0000, 5'h0B, 1'b0, 1'b0, 5'h12};
    vecs[3] = '{16'h0000, 5'h1F, 4'h0, 4'h0, 16'h0000, 16'h0000, 5'h00, 1'b0, 1'b0, 5'h12};
    vecs[4] = '{16'hB37F, 5'h05, 4'h3, 4'h0, 16'h007F, 16'h007F, 5'h1B, 1'b1, 1'b0, 5'h05};
    vecs[5] = '{16'h6180, 5'h08, 4'h1, 4'h0, 16'hFF80, 16'hFF80, 5'h16, 1'b1, 1'b1, 5'h08};
    vecs[6] = '{16'h0A2C, 5'h00, 4'hA, 4'hC, 16'h0000, 16'h0000, 5'h02, 1'b0, 1'b1, 5'h00};

    rst_n = 1'b0;
    bus.Inst = 16'h0153;
    bus.InstValid = 1'b1;
    flags = 5'h1F;
    #1;
    chk("rst_ready", 32'(bus.InstReady), 32'd1);
    chk("rst_outs", 32'({rd, rs, imm, op, ims}), 32'd0);
    chk("rst_psr_en_ret", 32'({psr, en, ret}), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("rst_no_accept", 32'({rd, rs, op}), 32'd0);
    bus.InstValid = 1'b0;
    rst_n = 1'b1;

    // Idle: no valid word for ten cycles.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); @(negedge clk);
      chk("idle_ready", 32'(bus.InstReady), 32'd1);
      chk("idle_en", 32'(en), 32'd0);
      chk("idle_outs", 32'({rd, rs, imm, op, ims, psr, ret}), 32'd0);
    end

    for (int i = 0; i < 7; i++)
      do_inst(vecs[i].inst, vecs[i].flags, vecs[i].rd, vecs[i].rs, vecs[i].imm,
              vecs[i].imm_z, vecs[i].op, vecs[i].ims, vecs[i].en, vecs[i].psr);
    psr_m = 5'h00;

    // Back-to-back with InstValid held high.
    flags = 5'h09;
    bus.Inst = 16'h0153;
    bus.InstValid = 1'b1;
    acc_n = 0; en_n = 0;
    acc_at[0] = -1; acc_at[1] = -1;
    for (int k = 0; k < 7; k++) begin
      if (bus.InstReady && bus.InstValid) begin
        if (acc_n < 2) acc_at[acc_n] = k;
        acc_n++;
      end
      @(posedge clk); @(negedge clk);
      if (acc_n == 1) bus.Inst = 16'h0263;
      if (acc_n == 2) bus.InstValid = 1'b0;
      if (en) begin
        en_n++;
        chk("b2b_rdest", 32'(rd), (en_n == 1) ? 32'd1 : 32'd2);
      end
    end
    chk("b2b_accepts", 32'(acc_n), 32'd2);
    chk("b2b_first_edge", 32'(acc_at[0]), 32'd0);
    chk("b2b_second_edge", 32'(acc_at[1]), 32'd3);
    chk("b2b_en_pulses", 32'(en_n), 32'd2);
    chk("b2b_psr", 32'(psr), 32'h09);
    $display("back-to-back accepts=%0d at %0d,%0d en_pulses=%0d", acc_n, acc_at[0], acc_at[1], en_n);

    // Reset dropped in EXEC with Psr = 1F.
    do_inst(16'h0153, 5'h1F, 4'h1, 4'h3, 16'h0, 16'h0, 5'h05, 1'b0, 1'b1, 5'h1F);
    bus.Inst = 16'h0263;
    bus.InstValid = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("mid_exec_en", 32'(en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en_ret", 32'({en, ret}), 32'd0);
    chk("mid_rst_psr", 32'(psr), 32'd0);
    chk("mid_rst_ready", 32'(bus.InstReady), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("mid_rst_hold", 32'({rd, rs, op, psr, en}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rel_accept_ready", 32'(bus.InstReady), 32'd0);
    chk("rel_accept_rdest", 32'(rd), 32'd2);
    bus.InstValid = 1'b0;
    flags = 5'h06;
    @(posedge clk); @(negedge clk);
    chk("rel_exec_en", 32'(en), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("rel_psr", 32'(psr), 32'h06);
    $display("reset-in-exec recovered rdest=%h psr=%h", rd, psr);
    psr_m = 5'h06;

    // Randomized words against the decode model.
    for (int i = 0; i < 40; i++) begin
      logic [4:0] f;
      dec_t dz;
      case ($urandom_range(0, 9))
        0: w = 16'h0000;
        1: w = {4'h0, 4'($urandom), 4'hB, 4'($urandom)};
        default: w = 16'($urandom);
      endcase
      f  = 5'($urandom);
      d  = model(w, 16'h0000);
      dz = model(w, 16'h0020);
      if (d.upd) psr_m = f;
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        @(posedge clk); @(negedge clk);
        chk("gap_en", 32'(en), 32'd0);
      end
      do_inst(w, f, d.rd, d.rs, d.imm, dz.imm, d.op, d.ims, d.wb, psr_m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Instruction sequencer that drives the register-file/ALU datapath from the control side. It accepts 16-bit instruction words over a valid/ready handshake and decodes them into register indices, immediate, source select and ALU opcode. It times the write-enable to match the datapath's registered ALU source operand and captures the ALU flags into a status register. It sits between instruction memory and the regfile/ALU datapath.

## Interface
- `CMP_CODE`, default 4'hB: extended opcode (register form) / major opcode (immediate form) meaning compare. Updates flags, no writeback.
- `ZEXT_MASK`, default 16'h0000: bit k set means immediate-form major opcode k zero-extends its imm8; clear means sign-extend.
- `Clk  in  1`: single clock, all state on rising edge.
- `Rst  in  1`: asynchronous, active-low reset.
- `Inst  in  16`: instruction word.
- `InstValid  in  1`: Inst is valid.
- `InstReady  out  1`: sequencer accepts an instruction this cycle.
- `Flags  in  5`: combinational flags from the ALU.
- `RdestRegLoc  out  4`: destination/first-operand register index.
- `RsrcRegLoc  out  4`: source register index.
- `Imm  out  16`: extended immediate.
- `Imm_s  out  1`: 1 selects Imm as the ALU source, 0 selects the Rsrc register.
- `OpCode  out  5`: ALU operation.
- `En  out  1`: regfile write enable.
- `Psr  out  5`: captured status flags.
- `Retire  out  1`: one-cycle pulse when an instruction completes.

## Operation
- State machine: FETCH -> DECODE -> EXEC -> FETCH. Reset state is FETCH.
- FETCH
  - InstReady = 1 (combinational from state).
  - On InstValid && InstReady at the clock edge: latch decoded fields and go to DECODE.
  - Otherwise stay in FETCH.
- Decode, applied at the accepting edge. All outputs are registered and held through DECODE and EXEC.
  - Register form (Inst[15:12]==0): RdestRegLoc=Inst[11:8], RsrcRegLoc=Inst[3:0], OpCode={1'b0,Inst[7:4]}, Imm_s=0, Imm=0.
  - Immediate form (Inst[15:12]!=0): RdestRegLoc=Inst[11:8], RsrcRegLoc=0, OpCode={1'b1,Inst[15:12]}, Imm_s=1.
    - Imm = {8{Inst[7]},Inst[7:0]} if ZEXT_MASK[Inst[15:12]]==0.
    - Imm = {8'h00,Inst[7:0]} if ZEXT_MASK[Inst[15:12]]==1.
  - NOP: Inst==16'h0000. Decodes as register form but is marked no-writeback and no-flag-update.
  - Compare: register form with Inst[7:4]==CMP_CODE, or immediate form with Inst[15:12]==CMP_CODE. Marked no-writeback; flags are updated.
- DECODE: one cycle with no side effects. The datapath registers its ALU source operand (Rsrc or Imm) at the end of this cycle.
- EXEC: one cycle.
  - En=1 unless the instruction is NOP or compare.
  - Retire=1.
  - At the closing edge: Psr <= Flags unless NOP, and the state returns to FETCH.
- En and Retire are never high outside EXEC.
- Fields are held constant from DECODE through EXEC. They change only on an accepting FETCH edge.

## Timing
- Reset (Rst low, async):
  - state=FETCH.
  - RdestRegLoc=0, RsrcRegLoc=0, Imm=0, Imm_s=0, OpCode=0, Psr=0.
  - En=0, Retire=0.
  - InstReady reads 1, but no handshake completes while Rst is low.
- Latency: instruction accepted at edge N, En/Retire high in cycle N+1..N+2 (EXEC), regfile write and Psr update at edge N+2.
- Throughput: one instruction per 3 cycles maximum. InstReady is low in DECODE and EXEC.
- InstValid low in FETCH: stall indefinitely, all outputs held, En=0.
- InstValid high during DECODE/EXEC: ignored. The word must be held by the source until InstReady.
- Reset asserted in DECODE or EXEC: instruction is abandoned, no write, Psr cleared. After release the sequencer is in FETCH.
- Psr changes only at the closing edge of EXEC or on reset.

## Test plan
- Reset then Inst=16'h0153 valid: next cycle Rdest=1, Rsrc=3, OpCode=5'b00101, Imm_s=0. En=1 exactly one cycle, 2 cycles after acceptance. Retire coincident. InstReady low for 2 cycles.
- Inst=16'h52F0 with ZEXT_MASK=0: OpCode=5'b10101, Imm_s=1, Imm=16'hFFF0, Rdest=2. Repeat with ZEXT_MASK=16'h0020: Imm=16'h00F0.
- Inst=16'h04B7 (CMP): En stays 0, Retire pulses, Psr takes the Flags value driven during EXEC (e.g. 5'b10010). Inst=16'h0000: En=0, Psr unchanged.
- InstValid held high for back-to-back words 16'h0153, 16'h0263: accepted at edges 0 and 3. No overlap of fields. Exactly two En pulses.
- Rst dropped mid-EXEC with Psr=5'h1F: En, Retire and Psr go to 0 immediately. No write completes. First accept occurs one edge after release.
- InstValid low for 10 cycles after reset: InstReady stays high, En stays low, outputs hold reset values.
